// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the serial comparator path and its word-pair feeder.
package serial_cmp_pkg;

  localparam int SER_WIDTH_MIN = 2;
  localparam int SER_WIDTH_MAX = 32;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_e;

endpackage

// File: rtl/serial_word_pair_serializer.sv
// Shifts a pair of parallel words out MSB first on two lock-stepped serial lines,
// with frame markers and a one-entry pending buffer for bubble-free frames.
module serial_word_pair_serializer
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_a,
  output logic             out_b,
  output logic             out_first,
  output logic             out_last
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  ser_state_e       state_r, state_s;
  logic [WIDTH-1:0] sh_a_r, sh_a_s;
  logic [WIDTH-1:0] sh_b_r, sh_b_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [WIDTH-1:0] pend_a_r, pend_a_s;
  logic [WIDTH-1:0] pend_b_r, pend_b_s;
  logic             pend_valid_r, pend_valid_s;
  logic             in_ready_r, in_ready_s;
  logic             out_valid_r, out_valid_s;
  logic             out_a_r, out_a_s;
  logic             out_b_r, out_b_s;
  logic             out_first_r, out_first_s;
  logic             out_last_r, out_last_s;
  logic             xfer_s;
  logic             accept_s;
  logic             shifter_free_s;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_a     = out_a_r;
  assign out_b     = out_b_r;
  assign out_first = out_first_r;
  assign out_last  = out_last_r;

  // Next-state for shifter, bit counter, pending buffer and the registered outputs.
  always_comb begin
    xfer_s         = out_valid_r & out_ready;
    accept_s       = in_valid & in_ready_r;
    shifter_free_s = (state_r == ST_IDLE) | (xfer_s & out_last_r);

    state_s      = state_r;
    sh_a_s       = sh_a_r;
    sh_b_s       = sh_b_r;
    cnt_s        = cnt_r;
    pend_a_s     = pend_a_r;
    pend_b_s     = pend_b_r;
    pend_valid_s = pend_valid_r;

    if (shifter_free_s) begin
      // A pending word always wins; accept cannot coincide because in_ready was low.
      if (pend_valid_r) begin
        state_s      = ST_SHIFT;
        sh_a_s       = pend_a_r;
        sh_b_s       = pend_b_r;
        cnt_s        = CNT_MAX;
        pend_valid_s = 1'b0;
      end else if (accept_s) begin
        state_s = ST_SHIFT;
        sh_a_s  = in_a;
        sh_b_s  = in_b;
        cnt_s   = CNT_MAX;
      end else begin
        state_s = ST_IDLE;
      end
    end else begin
      if (xfer_s) begin
        sh_a_s = {sh_a_r[WIDTH-2:0], 1'b0};
        sh_b_s = {sh_b_r[WIDTH-2:0], 1'b0};
        cnt_s  = cnt_r - CNT_ONE;
      end else begin
        cnt_s = cnt_r;
      end
      if (accept_s) begin
        pend_a_s     = in_a;
        pend_b_s     = in_b;
        pend_valid_s = 1'b1;
      end else begin
        pend_valid_s = pend_valid_r;
      end
    end

    in_ready_s  = ~pend_valid_s;
    out_valid_s = (state_s == ST_SHIFT);
    out_a_s     = out_valid_s & sh_a_s[WIDTH-1];
    out_b_s     = out_valid_s & sh_b_s[WIDTH-1];
    out_first_s = out_valid_s & (cnt_s == CNT_MAX);
    out_last_s  = out_valid_s & (cnt_s == CNT_ZERO);
  end

  // State and output registers; a reset aborts any frame and drops the pending word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      sh_a_r       <= '0;
      sh_b_r       <= '0;
      cnt_r        <= CNT_MAX;
      pend_a_r     <= '0;
      pend_b_r     <= '0;
      pend_valid_r <= 1'b0;
      in_ready_r   <= 1'b0;
      out_valid_r  <= 1'b0;
      out_a_r      <= 1'b0;
      out_b_r      <= 1'b0;
      out_first_r  <= 1'b0;
      out_last_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      sh_a_r       <= sh_a_s;
      sh_b_r       <= sh_b_s;
      cnt_r        <= cnt_s;
      pend_a_r     <= pend_a_s;
      pend_b_r     <= pend_b_s;
      pend_valid_r <= pend_valid_s;
      in_ready_r   <= in_ready_s;
      out_valid_r  <= out_valid_s;
      out_a_r      <= out_a_s;
      out_b_r      <= out_b_s;
      out_first_r  <= out_first_s;
      out_last_r   <= out_last_s;
    end
  end

endmodule

// File: tb/tb_serial_word_pair_serializer.sv
// Self-checking bench: directed scenarios plus random traffic against a word-queue model.
module tb_serial_word_pair_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_a;
  logic         out_b;
  logic         out_first;
  logic         out_last;

  serial_word_pair_serializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_first (out_first),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // Model: words accepted but not yet fully sent, plus bit index of the head word.
  logic [W-1:0] mq_a[$];
  logic [W-1:0] mq_b[$];
  int           m_idx = 0;
  bit           m_in_reset = 1'b1;
  int           n_checks = 0;
  int           n_pass = 0;
  int           valid_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ordy, output logic acc);
    logic e_rdy, e_val, e_a, e_b, e_f, e_l, xfer;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
    @(negedge clk);
    e_rdy = !m_in_reset && (mq_a.size() < 2);
    e_val = (mq_a.size() > 0);
    e_a = 1'b0; e_b = 1'b0; e_f = 1'b0; e_l = 1'b0;
    if (e_val) begin
      e_a = mq_a[0][W-1-m_idx];
      e_b = mq_b[0][W-1-m_idx];
      e_f = (m_idx == 0);
      e_l = (m_idx == W-1);
    end
    check("in_ready", in_ready, e_rdy);
    check("out_valid", out_valid, e_val);
    check("out_a", out_a, e_a);
    check("out_b", out_b, e_b);
    check("out_first", out_first, e_f);
    check("out_last", out_last, e_l);
    if (out_valid === 1'b1) valid_seen++;
    acc  = v && e_rdy && rst;
    xfer = ordy && e_val;
    @(posedge clk);
    if (!rst) begin
      mq_a.delete();
      mq_b.delete();
      m_idx      = 0;
      m_in_reset = 1'b1;
    end else begin
      m_in_reset = 1'b0;
      if (xfer) begin
        m_idx++;
        if (m_idx == W) begin
          m_idx = 0;
          void'(mq_a.pop_front());
          void'(mq_b.pop_front());
        end
      end
      if (acc) begin
        mq_a.push_back(a);
        mq_b.push_back(b);
      end
    end
    #1;
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, ordy, acc);
  endtask

  task automatic offer(input logic [W-1:0] a, input logic [W-1:0] b, input logic ordy);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) step(1'b1, a, b, ordy, acc);
    check("offer_accepted", acc, 1'b1);
  endtask

  logic [W-1:0] bb_a[3];
  logic [W-1:0] bb_b[3];

  initial begin
    logic acc;
    int   k;

    // Reset held for a few cycles, then released.
    rst = 1'b0;
    idle(3, 1'b1);
    rst = 1'b1;
    idle(2, 1'b1);

    // Single frame A5/3C.
    offer(8'hA5, 8'h3C, 1'b1);
    valid_seen = 0;
    idle(10, 1'b1);
    check("single_frame_len", valid_seen, 32'd8);

    // Three word pairs offered continuously.
    bb_a[0] = 8'hFF; bb_b[0] = 8'h00;
    bb_a[1] = 8'h00; bb_b[1] = 8'hFF;
    bb_a[2] = 8'h81; bb_b[2] = 8'h81;
    valid_seen = 0;
    k = 0;
    for (int c = 0; c < 60 && k < 3; c++) begin
      step(1'b1, bb_a[k], bb_b[k], 1'b1, acc);
      if (acc) k++;
    end
    check("b2b_all_accepted", k, 32'd3);
    idle(30, 1'b1);
    check("b2b_valid_cycles", valid_seen, 32'd24);

    // Backpressure for 5 cycles after bit 3.
    offer(8'hA5, 8'h3C, 1'b1);
    idle(4, 1'b1);
    idle(5, 1'b0);
    idle(10, 1'b1);

    // Reset mid-frame with a pending word.
    offer(8'hC3, 8'h5A, 1'b1);
    offer(8'h77, 8'h11, 1'b0);
    idle(5, 1'b1);
    rst = 1'b0;
    idle(1, 1'b1);
    rst = 1'b1;
    valid_seen = 0;
    idle(12, 1'b1);
    check("reset_discard", valid_seen, 32'd0);

    // Accept on the last-bit edge with an empty pending buffer.
    offer(8'h96, 8'h69, 1'b1);
    idle(7, 1'b1);
    step(1'b1, 8'h01, 8'h02, 1'b1, acc);
    check("last_edge_accept", acc, 1'b1);
    idle(12, 1'b1);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 2) != 0), W'($urandom), W'($urandom),
           ($urandom_range(0, 3) != 0), acc);
      if ($urandom_range(0, 499) == 0) rst = 1'b0;
      else rst = 1'b1;
    end
    rst = 1'b1;
    idle(40, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_word_pair_serializer.md
# serial_word_pair_serializer

Upstream feeder for the MSB-first serial comparator FSM. Accepts a pair of parallel WIDTH-bit words over a valid/ready handshake and shifts both out one bit per transfer, most significant bit first, on two lock-stepped serial lines. It also emits frame markers (first/last bit), which the consumer uses to clear its comparison state between words. A one-entry pending buffer allows back-to-back frames with no bubble cycle.

## Interface
- WIDTH, 8, bits per word; legal range 2..32
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-low reset
- in_valid  input  1  word pair offered
- in_ready  output  1  block can take a word pair this cycle
- in_a  input  WIDTH  operand A, parallel
- in_b  input  WIDTH  operand B, parallel
- out_valid  output  1  out_a/out_b carry a valid bit
- out_ready  input  1  consumer takes the current bit this cycle
- out_a  output  1  current bit of A, MSB first
- out_b  output  1  current bit of B, MSB first
- out_first  output  1  current bit is the MSB of its frame
- out_last  output  1  current bit is the LSB of its frame

## Operation
- Input accept: in_valid & in_ready on a rising edge. Output transfer: out_valid & out_ready on a rising edge.
- Shifter FSM states: ST_IDLE (no frame loaded) and ST_SHIFT (frame loaded, out_valid=1).
- The shifter holds sh_a and sh_b, plus a bit counter cnt. cnt runs from WIDTH-1 down to 0, width $clog2(WIDTH).
- out_a = sh_a[WIDTH-1], out_b = sh_b[WIDTH-1], out_first = (cnt==WIDTH-1), out_last = (cnt==0), all qualified by out_valid. When out_valid=0, out_a, out_b, out_first and out_last are all 0.
- On transfer with cnt!=0: shift sh_a and sh_b left by 1 and decrement cnt.
- "Shifter free" means state==ST_IDLE, or a transfer with out_last=1 occurs this cycle.
- Pending buffer: pend_a, pend_b, pend_valid. in_ready = ~pend_valid (and 0 while rst=0).
- On accept with shifter free and pend_valid=0: load the shifter directly and set cnt=WIDTH-1. State becomes ST_SHIFT.
- On accept otherwise: store the word pair in the pending buffer and set pend_valid=1.
- When the shifter is free and pend_valid=1: load the shifter from pending and clear pend_valid. This takes priority over any direct load. A simultaneous accept, which is legal only when pend_valid was 0, cannot occur in this case.
- When the shifter is free, pend_valid=0 and there is no accept: state becomes ST_IDLE.
- out_ready=0 freezes the shifter, cnt and all outputs. The pending buffer can still fill.

## Timing
- Reset values: out_valid=0, out_a=0, out_b=0, out_first=0, out_last=0, in_ready=0 while rst=0; in_ready=1 in the first cycle after release. State=ST_IDLE, pend_valid=0, cnt=WIDTH-1.
- Latency: a word accepted at edge T while idle has its MSB on out_a/out_b with out_valid=1 in the cycle after T.
- Throughput: with out_ready held at 1, one bit per cycle. Consecutive frames are contiguous: the cycle after the out_last transfer shows the next frame's out_first, provided a word was pending or accepted in that cycle.
- Simultaneous accept and last transfer with an empty pending buffer: the new word loads directly, with no bubble.
- Pending full: in_ready=0 until the pending word moves into the shifter. in_ready is 1 again in the cycle after that load.
- Reset mid-frame: the frame is aborted and the pending word is discarded. No partial frame resumes.
- in_a/in_b are sampled only on the accept edge; later changes have no effect.

## Structure
- Shared package serial_cmp_pkg holds:
  - typedef enum logic [0:0] for the serializer states (ST_IDLE, ST_SHIFT);
  - the WIDTH range bounds as localparams.
- The module is a single module with no sub-module. The pending buffer and shifter are inline registers. The next-state logic is one always_comb; the registers are one always_ff.

## Test plan
- Single frame, WIDTH=8, in_a=8'hA5, in_b=8'h3C, out_ready=1 -> out_a sequence 1,0,1,0,0,1,0,1 and out_b sequence 0,0,1,1,1,1,0,0 over 8 consecutive cycles, starting 1 cycle after accept; out_first on bit 0 only, out_last on bit 7 only.
- Back-to-back: three word pairs offered continuously (8'hFF/8'h00, 8'h00/8'hFF, 8'h81/8'h81) -> 24 contiguous valid cycles with no bubble; in_ready drops while the pending buffer is full; frame boundaries are flagged correctly.
- Backpressure: out_ready=0 for 5 cycles mid-frame after bit 3 -> out_a, out_b, out_first, out_last and cnt are held; the frame resumes at bit 4 with no bit lost or duplicated.
- Reset mid-frame: rst=0 for one cycle during bit 5 with a pending word -> out_valid=0 the next cycle, in_ready=1 after release, and no pending frame is emitted.
- Accept on last-bit edge with empty pending: new word 8'h01/8'h02 accepted in the same cycle as out_last transfer -> its MSB appears the next cycle with out_first=1.
- WIDTH=2 build: frames 2'b10/2'b01 back-to-back -> alternating out_first/out_last every cycle.
